aes_serial_cipher: RTL and testbench

- Bit-serial AES block cipher core with a SPI-like interface; one instance is either an encryptor or a decryptor, selected by parameter.
- Receives a 128-bit block and an Nk×32-bit key serially on miso, computes the full Nk/Nr AES transform, and returns the 128-bit result serially on mosi.
- Sits as a standalone crypto peripheral behind a chip-select; encrypt and decrypt instances share no state.

---
 rtl/aes_serial_cipher.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_aes_serial_cipher.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/aes_serial_cipher.sv
// aes_serial_cipher: bit-serial AES-128/192/256 cipher or inverse cipher.
// Serial frame handled on falling edges, one AES round per rising edge.
module aes_serial_cipher #(
   parameter int Nk      = 6,
   parameter int Nr      = 12,
   parameter int Nb      = 4,
   parameter bit DECRYPT = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic cs,
   input  logic miso,
   output logic mosi,
   output logic finished
);
   localparam int KW = Nk * 32;
   localparam int NW = Nb * (Nr + 1);
   localparam logic [8:0] loadLast = 9'(128 + KW - 1);
   localparam logic [3:0] lastRound = 4'(Nr);

   typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, DONE, SEND} stateType;

   stateType state, stateNext;

   logic [8:0]        loadCnt;
   logic [7:0]        sendCnt;
   logic [3:0]        roundCnt;
   logic [3:0]        roundIdx;
   logic              csLow;
   logic              computeDone;
   logic [127:0]      blockReg;
   logic [KW-1:0]     keyReg;
   logic [127:0]      aesState;
   logic [127:0]      resultReg;
   logic [127:0]      roundKey;
   logic [127:0]      roundTmp;
   logic [127:0]      roundOut;
   logic [NW*32-1:0]  keySched;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gfMul(input logic [7:0] a,
                                        input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
   function automatic logic [7:0] gfInv(input logic [7:0] x);
      logic [7:0] r;
      logic [7:0] p;
      r = 8'h01;
      p = x;
      for (int i = 1; i < 8; i++) begin
         p = gfMul(p, p);
         r = gfMul(r, p);
      end
      return r;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] v;
      v = gfInv(x);
      return v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] invSbox(input logic [7:0] y);
      return gfInv(rotl(y, 1) ^ rotl(y, 3) ^ rotl(y, 6) ^ 8'h05);
   endfunction

   function automatic logic [31:0] subWord(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [127:0] subBytes(input logic [127:0] s,
                                             input bit inv);
      logic [127:0] o;
      o = '0;
      for (int k = 0; k < 16; k++) begin
         if (inv) o[127-8*k -: 8] = invSbox(s[127-8*k -: 8]);
         else     o[127-8*k -: 8] = sbox(s[127-8*k -: 8]);
      end
      return o;
   endfunction

   // AES byte r+4c is row r, column c; row r rotates left by r
   function automatic logic [127:0] shiftRows(input logic [127:0] s,
                                              input bit inv);
      logic [127:0] o;
      int src;
      int dst;
      o = '0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            src = inv ? (r + 4*c) : (r + 4*((c + r) % 4));
            dst = inv ? (r + 4*((c + r) % 4)) : (r + 4*c);
            o[127-8*dst -: 8] = s[127-8*src -: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [31:0] mixCol(input logic [31:0] col,
                                          input bit inv);
      logic [7:0]  a [4];
      logic [7:0]  m [4];
      logic [7:0]  b;
      logic [31:0] o;
      o = '0;
      if (inv) begin
         m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
      end else begin
         m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01;
      end
      for (int k = 0; k < 4; k++) a[k] = col[31-8*k -: 8];
      for (int i = 0; i < 4; i++) begin
         b = 8'h00;
         for (int k = 0; k < 4; k++) b = b ^ gfMul(m[(k - i + 4) % 4], a[k]);
         o[31-8*i -: 8] = b;
      end
      return o;
   endfunction

   function automatic logic [127:0] mixColumns(input logic [127:0] s,
                                               input bit inv);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) o[127-32*c -: 32] = mixCol(s[127-32*c -: 32], inv);
      return o;
   endfunction

   // word i of the schedule lands at bits [32*i +: 32]
   function automatic logic [NW*32-1:0] expandKey(input logic [KW-1:0] key);
      logic [31:0]       w [NW];
      logic [31:0]       t;
      logic [7:0]        rc;
      logic [NW*32-1:0]  res;
      rc  = 8'h01;
      res = '0;
      for (int i = 0; i < NW; i++) begin
         if (i < Nk) begin
            w[i] = key[KW-1-32*i -: 32];
         end else begin
            t = w[i-1];
            if (i % Nk == 0) begin
               t  = subWord({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
               rc = xtime(rc);
            end else if (Nk > 6 && i % Nk == 4) begin
               t = subWord(t);
            end
            w[i] = w[i-Nk] ^ t;
         end
         res[32*i +: 32] = w[i];
      end
      return res;
   endfunction

   assign keySched = expandKey(keyReg);
   assign finished = (state == DONE) || (state == SEND);

   // round key selection and one full cipher / inverse-cipher round
   always_comb begin
      roundIdx = DECRYPT ? (lastRound - roundCnt) : roundCnt;
      roundKey = '0;
      for (int j = 0; j < 4; j++) begin
         roundKey[127-32*j -: 32] = keySched[32*(4*int'(roundIdx) + j) +: 32];
      end
      if (!DECRYPT) begin
         roundTmp = shiftRows(subBytes(aesState, 1'b0), 1'b0);
         if (roundCnt != lastRound) roundTmp = mixColumns(roundTmp, 1'b0);
         roundOut = roundTmp ^ roundKey;
      end else begin
         roundTmp = subBytes(shiftRows(aesState, 1'b1), 1'b1) ^ roundKey;
         if (roundCnt != lastRound) roundTmp = mixColumns(roundTmp, 1'b1);
         roundOut = roundTmp;
      end
   end

   // frame state register, advanced on the serial (falling) edge
   always_ff @(negedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= stateNext;
   end

   // next-state decode from cs, frame counters and round completion
   always_comb begin
      stateNext = state;
      unique case (state)
         IDLE:    if (cs) stateNext = LOAD;
         LOAD: begin
            if (!cs)                      stateNext = IDLE;
            else if (loadCnt == loadLast) stateNext = COMPUTE;
         end
         COMPUTE: if (computeDone) stateNext = DONE;
         DONE:    if (cs && csLow) stateNext = SEND;
         SEND:    if (!cs) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // serial shift-in of block/key and shift-out of the result
   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         loadCnt  <= '0;
         sendCnt  <= '0;
         csLow    <= 1'b0;
         blockReg <= '0;
         keyReg   <= '0;
         mosi     <= 1'b0;
      end else begin
         mosi <= 1'b0;
         case (state)
            IDLE: begin
               loadCnt <= '0;
               sendCnt <= '0;
               csLow   <= 1'b0;
            end
            LOAD: begin
               if (!cs) begin
                  loadCnt <= '0;
               end else begin
                  loadCnt <= loadCnt + 9'd1;
                  if (loadCnt < 9'd128) blockReg <= {miso, blockReg[127:1]};
                  else                  keyReg   <= {miso, keyReg[KW-1:1]};
               end
            end
            COMPUTE: csLow <= 1'b0;
            DONE: begin
               if (!cs) begin
                  csLow <= 1'b1;
               end else if (csLow) begin
                  mosi    <= resultReg[0];
                  sendCnt <= 8'd1;
               end
            end
            SEND: begin
               if (cs && sendCnt < 8'd128) begin
                  mosi    <= resultReg[sendCnt[6:0]];
                  sendCnt <= sendCnt + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // round engine: initial AddRoundKey, then Nr rounds, then latch result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         roundCnt    <= '0;
         computeDone <= 1'b0;
         aesState    <= '0;
         resultReg   <= '0;
      end else if (state != COMPUTE) begin
         roundCnt    <= '0;
         computeDone <= 1'b0;
      end else if (!computeDone) begin
         roundCnt <= roundCnt + 4'd1;
         if (roundCnt == 4'd0) begin
            aesState <= blockReg ^ roundKey;
         end else begin
            aesState <= roundOut;
            if (roundCnt == lastRound) begin
               resultReg   <= roundOut;
               computeDone <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_aes_serial_cipher.sv
// tb_aes_serial_cipher: encrypt + decrypt instances, scoreboard of results.
// Covers FIPS vectors, chained streaming, long cs hold, mid-frame resets.
module tb_aes_serial_cipher;
   localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT1  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [191:0] KEY1 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
   localparam logic [127:0] PT2  = 128'hffeeddccbbaa99887766554433221100;
   localparam logic [127:0] CT2  = 128'hb81a4b66ebdee44d6fc0f886cc442d7b;
   localparam logic [191:0] KEY2 = 192'h123456789876543223456789876543212345789876543210;

   logic clk = 1'b0;
   logic rst;
   logic encCs, encMiso, encMosi, encFinished;
   logic decCs, decMisoTb, decMiso, decMosi, decFinished;
   logic chain;
   int total = 0;
   int bad = 0;
   logic [127:0] expQ[$];

   always #5 clk = ~clk;

   assign decMiso = chain ? encMosi : decMisoTb;

   aes_serial_cipher #(.Nk(6), .Nr(12), .Nb(4), .DECRYPT(1'b0)) uEnc (
      .clk(clk), .rst(rst), .cs(encCs), .miso(encMiso),
      .mosi(encMosi), .finished(encFinished)
   );

   aes_serial_cipher #(.Nk(6), .Nr(12), .Nb(4), .DECRYPT(1'b1)) uDec (
      .clk(clk), .rst(rst), .cs(decCs), .miso(decMiso),
      .mosi(decMosi), .finished(decFinished)
   );

   task automatic checkVal(input string tag, input logic [127:0] got,
                           input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic setCs(input bit which, input logic v);
      if (which) decCs = v;
      else       encCs = v;
   endtask

   function automatic logic getMosi(input bit which);
      return which ? decMosi : encMosi;
   endfunction

   function automatic logic getFin(input bit which);
      return which ? decFinished : encFinished;
   endfunction

   task automatic pulseRst(input bit which, input string tag);
      rst = 1'b1;
      encCs = 1'b0;
      decCs = 1'b0;
      #1;
      checkVal({tag, "Mosi"}, 128'(getMosi(which)), '0);
      checkVal({tag, "Fin"}, 128'(getFin(which)), '0);
      #1 rst = 1'b0;
   endtask

   task automatic loadFrame(input bit which, input logic [127:0] blk,
                            input logic [191:0] key, input int abortAt);
      logic [319:0] frame;
      frame = {key, blk};
      @(posedge clk);
      setCs(which, 1'b1);
      for (int n = 0; n < 320; n++) begin
         @(posedge clk);
         if (n == abortAt) begin
            #2;
            pulseRst(which, "rstLoad");
            return;
         end
         if (which) decMisoTb = frame[n];
         else       encMiso = frame[n];
      end
      @(posedge clk);
      setCs(which, 1'b0);
   endtask

   task automatic waitFin(input bit which, input string tag);
      repeat (28) @(posedge clk);
      #1;
      checkVal(tag, 128'(getFin(which)), 128'd1);
   endtask

   task automatic readCheck(input bit which, input string tag,
                            input int abortAt);
      logic [127:0] got;
      logic [127:0] exp;
      got = '0;
      exp = expQ.pop_front();
      @(posedge clk);
      setCs(which, 1'b1);
      for (int n = 0; n < 128; n++) begin
         @(posedge clk);
         #1;
         if (n == abortAt) begin
            pulseRst(which, "rstSend");
            return;
         end
         got[n] = getMosi(which);
      end
      @(posedge clk);
      setCs(which, 1'b0);
      checkVal(tag, got, exp);
      @(posedge clk);
      #1;
      checkVal({tag, "FinClr"}, 128'(getFin(which)), '0);
   endtask

   initial begin
      logic [127:0] got;
      logic [191:0] k;
      logic holdOr;
      rst = 1'b0;
      encCs = 1'b0;
      encMiso = 1'b0;
      decCs = 1'b0;
      decMisoTb = 1'b0;
      chain = 1'b0;
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkVal("rstEncMosi", 128'(encMosi), '0);
      checkVal("rstEncFin", 128'(encFinished), '0);
      checkVal("rstDecMosi", 128'(decMosi), '0);
      checkVal("rstDecFin", 128'(decFinished), '0);
      rst = 1'b0;

      loadFrame(1'b0, PT1, KEY1, -1);
      expQ.push_back(CT1);
      waitFin(1'b0, "enc1Fin");
      readCheck(1'b0, "enc1", -1);

      loadFrame(1'b1, CT1, KEY1, -1);
      expQ.push_back(PT1);
      waitFin(1'b1, "dec1Fin");
      readCheck(1'b1, "dec1", -1);

      loadFrame(1'b0, PT2, KEY2, -1);
      expQ.push_back(CT2);
      waitFin(1'b0, "enc2Fin");
      readCheck(1'b0, "enc2", -1);

      loadFrame(1'b1, CT2, KEY2, -1);
      expQ.push_back(PT2);
      waitFin(1'b1, "dec2Fin");
      readCheck(1'b1, "dec2", -1);

      loadFrame(1'b0, PT1, KEY1, -1);
      expQ.push_back(CT1);
      expQ.push_back(PT1);
      waitFin(1'b0, "chainEncFin");
      k = KEY1;
      got = '0;
      holdOr = 1'b0;
      @(posedge clk);
      chain = 1'b1;
      encCs = 1'b1;
      decCs = 1'b1;
      for (int n = 0; n < 320; n++) begin
         @(posedge clk);
         if (n == 128) chain = 1'b0;
         if (n >= 128) decMisoTb = k[n-128];
         #1;
         if (n < 128) got[n] = encMosi;
         else         holdOr = holdOr | encMosi;
      end
      @(posedge clk);
      encCs = 1'b0;
      decCs = 1'b0;
      checkVal("chainEnc", got, expQ.pop_front());
      checkVal("holdMosi", 128'(holdOr), '0);
      @(posedge clk);
      #1;
      checkVal("holdFinClr", 128'(encFinished), '0);
      waitFin(1'b1, "chainDecFin");
      readCheck(1'b1, "chainDec", -1);

      loadFrame(1'b0, PT2, KEY2, 60);
      loadFrame(1'b0, PT2, KEY2, -1);
      expQ.push_back(CT2);
      waitFin(1'b0, "postLoadRstFin");
      readCheck(1'b0, "postLoadRst", -1);

      loadFrame(1'b0, PT1, KEY1, -1);
      expQ.push_back(CT1);
      waitFin(1'b0, "midSendFin");
      readCheck(1'b0, "midSend", 40);
      loadFrame(1'b0, PT2, KEY2, -1);
      expQ.push_back(CT2);
      waitFin(1'b0, "postSendRstFin");
      readCheck(1'b0, "postSendRst", -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
